test_sampler_s00_axi: RTL and testbench

AXI4 full-protocol slave for the TestSampler IP's S00_AXI port. It is the stage directly downstream of the bus master. It terminates write and read bursts into a word-addressed sample memory and returns data and responses. One transaction is in flight at a time. Supports FIXED, INCR and WRAP bursts of up to 256 beats at 32-bit width.

---
 rtl/test_sampler_pkg.sv | 22 ++
 rtl/test_sampler_addr_gen.sv | 51 +++++
 rtl/test_sampler_s00_axi.sv | 228 ++++++++++++++++++++++
 tb/tb_test_sampler_s00_axi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_sampler_pkg.sv
// Shared encodings, FSM state type and sizing helper for the TestSampler S00_AXI slave.
package test_sampler_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_RESP = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

    function automatic int unsigned word_idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/test_sampler_addr_gen.sv
// Combinational next-beat address and burst legality check, shared by the write and read paths.
module test_sampler_addr_gen
    import test_sampler_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IDX_W  = 6
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              legal_o
);

    localparam logic [ADDR_W-1:0] MEM_MASK = ADDR_W'((64'd1 << (IDX_W + 2)) - 64'd1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(64'd4);

    logic              wrap_len_ok_s;
    logic [ADDR_W-1:0] sum_s;
    logic [ADDR_W-1:0] win_mask_s;

    // WRAP windows must be a power-of-two beat count of 2, 4, 8 or 16
    always_comb begin
        case (len_i)
            8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok_s = 1'b1;
            default:                 wrap_len_ok_s = 1'b0;
        endcase
    end

    // Only the bits inside the window advance; FIXED has an empty window
    always_comb begin
        sum_s      = addr_i + STEP;
        win_mask_s = MEM_MASK;
        case (burst_i)
            BURST_FIXED: win_mask_s = '0;
            BURST_WRAP: begin
                if (wrap_len_ok_s) begin
                    win_mask_s = ADDR_W'({len_i, 2'b11}) & MEM_MASK;
                end else begin
                    win_mask_s = MEM_MASK;
                end
            end
            default:     win_mask_s = MEM_MASK;
        endcase
        next_addr_o = (addr_i & ~win_mask_s) | (sum_s & win_mask_s);
        legal_o     = (size_i == 3'd2) && (burst_i != 2'd3) &&
                      !((burst_i == BURST_WRAP) && !wrap_len_ok_s);
    end

endmodule

// File: rtl/test_sampler_s00_axi.sv
// AXI4 slave terminating one burst at a time into a word-addressed sample memory.
// Optional TEST_SAMPLER_CAPTURE_EN adds a streaming sample capture port into the same memory.
module test_sampler_s00_axi
    import test_sampler_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_MEM_DEPTH        = 64
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [7:0]                      s00_axi_awlen,
    input  logic [2:0]                      s00_axi_awsize,
    input  logic [1:0]                      s00_axi_awburst,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wlast,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_bid,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [7:0]                      s00_axi_arlen,
    input  logic [2:0]                      s00_axi_arsize,
    input  logic [1:0]                      s00_axi_arburst,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rlast,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
`ifdef TEST_SAMPLER_CAPTURE_EN
    ,
    input  logic                                      sample_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             sample_data,
    output logic [word_idx_width(C_MEM_DEPTH)-1:0]    sample_wptr,
    output logic                                      sample_drop
`endif
);

    localparam int unsigned IDX_W = word_idx_width(C_MEM_DEPTH);

    state_e                            state_q, state_d;
    logic [C_S_AXI_ID_WIDTH-1:0]       id_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [7:0]                        len_q;
    logic [2:0]                        size_q;
    logic [1:0]                        burst_q;
    logic [7:0]                        beat_q;
    logic                              wl_err_q;
    logic                              live_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]     mem_q [C_MEM_DEPTH];

    logic [C_S_AXI_ADDR_WIDTH-1:0]     next_addr_s;
    logic                              legal_s;
    logic                              aw_hs_s, ar_hs_s, w_hs_s, r_hs_s;
    logic                              last_beat_s, err_s;

    test_sampler_addr_gen #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr_s),
        .legal_o     (legal_s)
    );

    // live_q keeps every ready low while reset is held and for the first edge after release
    assign s00_axi_awready = live_q && (state_q == ST_IDLE);
    assign s00_axi_arready = s00_axi_awready && !s00_axi_awvalid;
    assign s00_axi_wready  = (state_q == ST_WR_DATA);
    assign s00_axi_bvalid  = (state_q == ST_WR_RESP);
    assign s00_axi_rvalid  = (state_q == ST_RD_DATA);
    assign s00_axi_bid     = id_q;
    assign s00_axi_rid     = id_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rlast   = s00_axi_rvalid && last_beat_s;
    assign s00_axi_bresp   = (s00_axi_bvalid && err_s) ? RESP_SLVERR : RESP_OKAY;
    assign s00_axi_rresp   = (s00_axi_rvalid && err_s) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs_s     = s00_axi_awvalid && s00_axi_awready;
    assign ar_hs_s     = s00_axi_arvalid && s00_axi_arready;
    assign w_hs_s      = s00_axi_wvalid && s00_axi_wready;
    assign r_hs_s      = s00_axi_rvalid && s00_axi_rready;
    assign last_beat_s = (beat_q == len_q);
    assign err_s       = !legal_s || wl_err_q;

    // Transaction sequencing; exits are driven by the beat count, not by wlast
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    state_d = ST_WR_DATA;
                end else if (ar_hs_s) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (w_hs_s && last_beat_s) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (s00_axi_bready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_DATA: begin
                if (r_hs_s && last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, latched burst attributes, beat counter and read data staging
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q  <= ST_IDLE;
            live_q   <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'd0;
            beat_q   <= 8'd0;
            wl_err_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (aw_hs_s) begin
                id_q     <= s00_axi_awid;
                addr_q   <= s00_axi_awaddr;
                len_q    <= s00_axi_awlen;
                size_q   <= s00_axi_awsize;
                burst_q  <= s00_axi_awburst;
                beat_q   <= 8'd0;
                wl_err_q <= 1'b0;
            end else if (ar_hs_s) begin
                id_q     <= s00_axi_arid;
                addr_q   <= s00_axi_araddr;
                len_q    <= s00_axi_arlen;
                size_q   <= s00_axi_arsize;
                burst_q  <= s00_axi_arburst;
                beat_q   <= 8'd0;
                wl_err_q <= 1'b0;
                rdata_q  <= mem_q[s00_axi_araddr[IDX_W+1:2]];
            end else if (w_hs_s) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr_s;
                if (s00_axi_wlast != last_beat_s) begin
                    wl_err_q <= 1'b1;
                end
            end else if (r_hs_s) begin
                beat_q  <= beat_q + 8'd1;
                addr_q  <= next_addr_s;
                rdata_q <= mem_q[next_addr_s[IDX_W+1:2]];
            end
        end
    end

`ifdef TEST_SAMPLER_CAPTURE_EN
    logic [IDX_W-1:0] wptr_q;
    logic             drop_q;
    logic             cap_we_s;

    assign cap_we_s    = sample_valid && live_q && (state_q != ST_WR_DATA);
    assign sample_wptr = wptr_q;
    assign sample_drop = drop_q;

    // Capture pointer advances per accepted sample; drops during bus writes are sticky
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wptr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (cap_we_s) begin
                wptr_q <= wptr_q + IDX_W'(1);
            end
            if (sample_valid && (state_q == ST_WR_DATA)) begin
                drop_q <= 1'b1;
            end
        end
    end
`endif

    // Sample memory is deliberately not reset so contents survive a bus reset
    always_ff @(posedge s00_axi_aclk) begin
        if (w_hs_s && (size_q == 3'd2)) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                if (s00_axi_wstrb[b]) begin
                    mem_q[addr_q[IDX_W+1:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
            end
        end
`ifdef TEST_SAMPLER_CAPTURE_EN
        else if (cap_we_s) begin
            mem_q[wptr_q] <= sample_data;
        end
`endif
    end

endmodule

// File: tb/tb_test_sampler_s00_axi.sv
// Directed self-checking bench for test_sampler_s00_axi with hand-computed expectations.
module tb_test_sampler_s00_axi;

    logic        aclk;
    logic        aresetn;
    logic [0:0]  awid, bid, arid, rid;
    logic [7:0]  awaddr, awlen, araddr, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];
    logic        rlbuf [16];
    logic [1:0]  rrbuf [16];
    logic [1:0]  resp;

    test_sampler_s00_axi dut (
        .s00_axi_aclk    (aclk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awid    (awid),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awlen   (awlen),
        .s00_axi_awsize  (awsize),
        .s00_axi_awburst (awburst),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wlast   (wlast),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bid     (bid),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_arid    (arid),
        .s00_axi_araddr  (araddr),
        .s00_axi_arlen   (arlen),
        .s00_axi_arsize  (arsize),
        .s00_axi_arburst (arburst),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rid     (rid),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rlast   (rlast),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {20'd0, awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid};
    endfunction

    task automatic axi_write(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int last_at, input logic id,
                             output logic [1:0] r);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
        check_val("aw_ready", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = 4'hF; wlast = (i == last_at); wvalid = 1'b1;
            #1;
            check_val("w_ready", 32'(wready), 32'd1);
            check_val("b_early", 32'(bvalid), 32'd0);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check_val("b_valid", 32'(bvalid), 32'd1);
        check_val("b_id", 32'(bid), 32'(id));
        r = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic [3:0] pat);
        int n, beats, cyc;
        logic        held;
        logic [31:0] hd;
        logic        hl;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        check_val("ar_ready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check_val("r_first", 32'(rvalid), 32'd1);
        beats = 0; cyc = 0; held = 1'b0; hd = 32'd0; hl = 1'b0;
        while (beats <= int'(len) && cyc < 100) begin
            rready = pat[cyc % 4];
            if (held) begin
                check_val("r_hold_d", rdata, hd);
                check_val("r_hold_l", 32'(rlast), 32'(hl));
            end
            if (rvalid && rready) begin
                check_val("r_id", 32'(rid), 32'(id));
                rbuf[beats] = rdata; rlbuf[beats] = rlast; rrbuf[beats] = rresp;
                beats++;
                held = 1'b0;
            end else begin
                held = rvalid; hd = rdata; hl = rlast;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        rready = 1'b0;
        check_val("r_beats", 32'(beats), 32'(len) + 32'd1);
        check_val("r_done", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp8 [8];
        aresetn = 1'b1;
        awid = 1'b0; awaddr = 8'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 1'b0; araddr = 8'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
        rready = 1'b0;
        #2 aresetn = 1'b0;
        #2;
        check_val("rst_outs", outs_vec(), 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        check_val("idle_awready", 32'(awready), 32'd1);
        check_val("idle_arready", 32'(arready), 32'd1);

        // INCR write 1..8 then read back
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        axi_write(8'h00, 8'd7, 3'd2, 2'd1, 7, 1'b1, resp);
        check_val("incr_bresp", 32'(resp), 32'd0);
        axi_read(8'h00, 8'd7, 2'd1, 1'b0, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            check_val("incr_rdata", rbuf[i], 32'(i + 1));
            check_val("incr_rlast", 32'(rlbuf[i]), (i == 7) ? 32'd1 : 32'd0);
            check_val("incr_rresp", 32'(rrbuf[i]), 32'd0);
        end

        // WRAP len 3 at 0x08 lands on words 2,3,0,1
        wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B; wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
        axi_write(8'h08, 8'd3, 3'd2, 2'd2, 3, 1'b0, resp);
        check_val("wrap_bresp", 32'(resp), 32'd0);
        axi_read(8'h00, 8'd3, 2'd1, 1'b1, 4'b1111);
        check_val("wrap_rd0", rbuf[0], 32'hCCCC_000C);
        check_val("wrap_rd1", rbuf[1], 32'hDDDD_000D);
        check_val("wrap_rd2", rbuf[2], 32'hAAAA_000A);
        check_val("wrap_rd3", rbuf[3], 32'hBBBB_000B);

        // Same-cycle AW/AR: write wins, read follows the B handshake
        awid = 1'b1; awaddr = 8'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        arid = 1'b0; araddr = 8'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        #1;
        check_val("coll_awready", 32'(awready), 32'd1);
        check_val("coll_arready", 32'(arready), 32'd0);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        check_val("coll_ar_wr", 32'(arready), 32'd0);
        wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        check_val("coll_bvalid", 32'(bvalid), 32'd1);
        check_val("coll_ar_b", 32'(arready), 32'd0);
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check_val("coll_ar_idle", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check_val("coll_rvalid", 32'(rvalid), 32'd1);
        check_val("coll_rdata", rdata, 32'h1234_5678);
        check_val("coll_rlast", 32'(rlast), 32'd1);
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check_val("coll_rdone", 32'(rvalid), 32'd0);

        // Stalled read, rready pattern 1,0,0,1
        axi_read(8'h00, 8'd3, 2'd1, 1'b0, 4'b1001);
        check_val("stall_rd0", rbuf[0], 32'hCCCC_000C);
        check_val("stall_rd3", rbuf[3], 32'hBBBB_000B);
        check_val("stall_last", 32'(rlbuf[3]), 32'd1);

        // Illegal WRAP length reads as INCR with SLVERR on each beat
        axi_read(8'h00, 8'd2, 2'd2, 1'b0, 4'b1111);
        check_val("badwrap_rd2", rbuf[2], 32'hAAAA_000A);
        for (int i = 0; i < 3; i++) check_val("badwrap_resp", 32'(rrbuf[i]), 32'd2);

        // awsize=1 write must not touch memory
        wbuf[0] = 32'hCAFE_0008;
        axi_write(8'h20, 8'd0, 3'd2, 2'd1, 0, 1'b0, resp);
        check_val("w8_bresp", 32'(resp), 32'd0);
        wbuf[0] = 32'hDEAD_BEEF;
        axi_write(8'h20, 8'd0, 3'd1, 2'd1, 0, 1'b1, resp);
        check_val("size1_bresp", 32'(resp), 32'd2);
        axi_read(8'h20, 8'd0, 2'd1, 1'b0, 4'b1111);
        check_val("size1_mem", rbuf[0], 32'hCAFE_0008);
        check_val("size1_rresp", 32'(rrbuf[0]), 32'd0);

        // Early wlast on beat 2 of 4: full burst accepted, SLVERR, data still stored
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h1111_0030 + 32'(i);
        axi_write(8'h30, 8'd3, 3'd2, 2'd1, 1, 1'b0, resp);
        check_val("wlast_bresp", 32'(resp), 32'd2);
        axi_read(8'h30, 8'd3, 2'd1, 1'b1, 4'b1111);
        check_val("wlast_mem0", rbuf[0], 32'h1111_0030);
        check_val("wlast_mem3", rbuf[3], 32'h1111_0033);
        check_val("wlast_rresp", 32'(rrbuf[3]), 32'd0);

        // Asynchronous reset mid read burst, then memory must be intact
        arid = 1'b1; araddr = 8'h00; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check_val("midrst_outs", outs_vec(), 32'd0);
        check_val("midrst_rdata", rdata, 32'd0);
        rready = 1'b0;
        @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        check_val("postrst_idle", 32'(rvalid), 32'd0);
        exp8[0] = 32'hCCCC_000C; exp8[1] = 32'hDDDD_000D; exp8[2] = 32'hAAAA_000A; exp8[3] = 32'hBBBB_000B;
        exp8[4] = 32'd5; exp8[5] = 32'd6; exp8[6] = 32'd7; exp8[7] = 32'd8;
        axi_read(8'h00, 8'd7, 2'd1, 1'b0, 4'b1111);
        for (int i = 0; i < 8; i++) check_val("postrst_rd", rbuf[i], exp8[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
